systolic_pe_db: RTL and testbench



---
 rtl/systolic_pe_db.sv | 129 ++++++++++++
 tb/tb_systolic_pe_db.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_db.sv
// Signed weight-stationary MAC cell with double-buffered weight and row-addressed weight-load chain.
// Optional build macro PE_SATURATE_EN: saturating accumulate with sticky sat_flag (wraps otherwise).
module systolic_pe_db #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32,
    parameter int ROW_IDX_W    = 4,
    parameter int ROW_ID       = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   act_in,
    input  logic                           act_valid_in,
    input  logic                           w_swap_in,
    input  logic signed [ACC_WIDTH-1:0]    psum_in,
    output logic signed [DATA_WIDTH-1:0]   act_out,
    output logic                           act_valid_out,
    output logic                           w_swap_out,
    output logic signed [ACC_WIDTH-1:0]    psum_out,
    output logic                           psum_valid_out,
    input  logic signed [WEIGHT_WIDTH-1:0] w_in,
    input  logic        [ROW_IDX_W-1:0]    w_row_in,
    input  logic                           w_valid_in,
    output logic signed [WEIGHT_WIDTH-1:0] w_out,
    output logic        [ROW_IDX_W-1:0]    w_row_out,
    output logic                           w_valid_out,
    output logic                           shadow_full,
    output logic                           sat_flag
);

    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
`ifdef PE_SATURATE_EN
    // One guard bit above the accumulator exposes signed overflow.
    localparam int SUM_W = ACC_WIDTH + 1;
`else
    localparam int SUM_W = ACC_WIDTH;
`endif

    logic signed [WEIGHT_WIDTH-1:0] active_w;
    logic signed [WEIGHT_WIDTH-1:0] shadow_w;
    logic                           capture_p0;
    logic                           swap_p0;
    logic signed [WEIGHT_WIDTH-1:0] w_eff_p0;
    logic signed [PROD_W-1:0]       prod_p0;
    logic signed [SUM_W-1:0]        sum_p0;
    logic signed [ACC_WIDTH-1:0]    psum_next_p0;
    logic                           ovf_p0;

`ifdef PE_SATURATE_EN
    function automatic logic sum_ovf(input logic signed [SUM_W-1:0] s);
        return s[SUM_W-1] != s[SUM_W-2];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SUM_W-1:0] s);
        logic signed [ACC_WIDTH-1:0] r;
        if (s[SUM_W-1] != s[SUM_W-2])
            r = s[SUM_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            r = s[ACC_WIDTH-1:0];
        return r;
    endfunction
`endif

    // Stage p0: weight select, multiply, accumulate
    always_comb begin
        capture_p0 = w_valid_in && (w_row_in == ROW_IDX_W'(ROW_ID));
        swap_p0    = act_valid_in && w_swap_in && shadow_full;
        w_eff_p0   = swap_p0 ? shadow_w : active_w;
        prod_p0    = act_in * w_eff_p0;
        sum_p0     = SUM_W'(psum_in) + SUM_W'(prod_p0);
`ifdef PE_SATURATE_EN
        psum_next_p0 = sat_acc(sum_p0);
        ovf_p0       = sum_ovf(sum_p0);
`else
        psum_next_p0 = sum_p0;
        ovf_p0       = 1'b0;
`endif
    end

    // Stage p1: registered outputs and weight buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            active_w       <= '0;
            shadow_w       <= '0;
            shadow_full    <= 1'b0;
            act_out        <= '0;
            act_valid_out  <= 1'b0;
            w_swap_out     <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            w_out          <= '0;
            w_row_out      <= '0;
            w_valid_out    <= 1'b0;
        end else begin
            w_out          <= w_in;
            w_row_out      <= w_row_in;
            w_valid_out    <= w_valid_in;
            act_valid_out  <= act_valid_in;
            psum_valid_out <= act_valid_in;
            w_swap_out     <= w_swap_in & act_valid_in;
            if (act_valid_in) begin
                act_out  <= act_in;
                psum_out <= psum_next_p0;
            end
            if (swap_p0)
                active_w <= shadow_w;
            if (capture_p0)
                shadow_w <= w_in;
            // A same-cycle capture refills the slot the swap just emptied.
            shadow_full <= capture_p0 | (shadow_full & ~swap_p0);
        end
    end

`ifdef PE_SATURATE_EN
    logic sat_q;
    always_ff @(posedge clk) begin
        if (rst)
            sat_q <= 1'b0;
        else if (act_valid_in && ovf_p0)
            sat_q <= 1'b1;
    end
    assign sat_flag = sat_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_p0;
    assign sat_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_pe_db.sv
// Directed bench for systolic_pe_db (ACC_WIDTH=17, ROW_ID=2); expectations follow PE_SATURATE_EN.
module tb_systolic_pe_db;

    localparam int DW = 8;
    localparam int WW = 8;
    localparam int AW = 17;
    localparam int RW = 4;
    localparam int RID = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] act_in;
    logic                 act_valid_in;
    logic                 w_swap_in;
    logic signed [AW-1:0] psum_in;
    logic signed [DW-1:0] act_out;
    logic                 act_valid_out;
    logic                 w_swap_out;
    logic signed [AW-1:0] psum_out;
    logic                 psum_valid_out;
    logic signed [WW-1:0] w_in;
    logic        [RW-1:0] w_row_in;
    logic                 w_valid_in;
    logic signed [WW-1:0] w_out;
    logic        [RW-1:0] w_row_out;
    logic                 w_valid_out;
    logic                 shadow_full;
    logic                 sat_flag;

    int checks = 0;
    int errors = 0;

    systolic_pe_db #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW),
        .ROW_IDX_W(RW), .ROW_ID(RID)
    ) dut (
        .clk(clk), .rst(rst),
        .act_in(act_in), .act_valid_in(act_valid_in), .w_swap_in(w_swap_in),
        .psum_in(psum_in),
        .act_out(act_out), .act_valid_out(act_valid_out), .w_swap_out(w_swap_out),
        .psum_out(psum_out), .psum_valid_out(psum_valid_out),
        .w_in(w_in), .w_row_in(w_row_in), .w_valid_in(w_valid_in),
        .w_out(w_out), .w_row_out(w_row_out), .w_valid_out(w_valid_out),
        .shadow_full(shadow_full), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic signed [DW-1:0] a, input logic sw,
                         input logic signed [AW-1:0] ps, input logic wv,
                         input logic signed [WW-1:0] w, input logic [RW-1:0] row);
        act_valid_in = av; act_in = a; w_swap_in = sw; psum_in = ps;
        w_valid_in = wv; w_in = w; w_row_in = row;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b0, 8'sd0, 4'd0);
        step(); step();
        chk("rst_psum", psum_out, 0);
        chk("rst_act", act_out, 0);
        chk("rst_pvld", psum_valid_out, 0);
        chk("rst_avld", act_valid_out, 0);
        chk("rst_sfull", shadow_full, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_wvld", w_valid_out, 0);
        rst = 1'b0;

        // load 3 to own row, then swap with act=-5, psum_in=7
        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b1, 8'sd3, 4'd2); step();
        chk("ld3_sfull", shadow_full, 1);
        chk("ld3_wout", w_out, 3);
        chk("ld3_wrow", w_row_out, 2);
        chk("ld3_wvld", w_valid_out, 1);
        drive(1'b1, -8'sd5, 1'b1, 17'sd7, 1'b0, 8'sd0, 4'd0); step();
        chk("sw3_psum", psum_out, -8);
        chk("sw3_pvld", psum_valid_out, 1);
        chk("sw3_sfull", shadow_full, 0);
        chk("sw3_swout", w_swap_out, 1);
        chk("sw3_act", act_out, -5);

        // load for another row: no capture, chain still forwards
        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b1, 8'sd2, 4'd5); step();
        chk("oth_sfull", shadow_full, 0);
        chk("oth_wout", w_out, 2);
        chk("oth_wvld", w_valid_out, 1);
        chk("oth_wrow", w_row_out, 5);
        chk("idle_psum_hold", psum_out, -8);
        chk("idle_pvld", psum_valid_out, 0);
        chk("idle_swout", w_swap_out, 0);
        drive(1'b1, 8'sd2, 1'b1, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        chk("empty_swap_psum", psum_out, 6);
        chk("empty_swap_swout", w_swap_out, 1);
        chk("empty_swap_sfull", shadow_full, 0);
        chk("empty_swap_wvld", w_valid_out, 0);

        // active 4, shadow -1
        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b1, 8'sd4, 4'd2); step();
        drive(1'b1, 8'sd0, 1'b1, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        chk("act4_psum", psum_out, 0);
        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b1, -8'sd1, 4'd2); step();
        chk("shm1_sfull", shadow_full, 1);
        drive(1'b1, 8'sd10, 1'b0, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        chk("noswap_psum", psum_out, 40);
        chk("noswap_sfull", shadow_full, 1);
        drive(1'b1, 8'sd10, 1'b1, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        chk("swap_m1_psum", psum_out, -10);
        chk("swap_m1_sfull", shadow_full, 0);

        // same-cycle capture 9 and swap with shadow 6
        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b1, 8'sd6, 4'd2); step();
        drive(1'b1, 8'sd1, 1'b1, 17'sd0, 1'b1, 8'sd9, 4'd2); step();
        chk("cs_psum", psum_out, 6);
        chk("cs_sfull", shadow_full, 1);
        drive(1'b1, 8'sd1, 1'b0, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        chk("cs_active6", psum_out, 6);
        drive(1'b1, 8'sd1, 1'b1, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        chk("cs_shadow9", psum_out, 9);
        chk("cs_sfull_after", shadow_full, 0);

        // accumulator boundaries with active 127
        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b1, 8'sd127, 4'd2); step();
        drive(1'b1, 8'sd0, 1'b1, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        drive(1'b1, 8'sd127, 1'b0, 17'sd49406, 1'b0, 8'sd0, 4'd0); step();
        chk("edge_max_psum", psum_out, 65535);
        chk("edge_max_sat", sat_flag, 0);
        drive(1'b1, 8'sd127, 1'b0, 17'sd65535, 1'b0, 8'sd0, 4'd0); step();
`ifdef PE_SATURATE_EN
        chk("ovf_pos_psum", psum_out, 65535);
        chk("ovf_pos_sat", sat_flag, 1);
`else
        chk("ovf_pos_psum", psum_out, -49408);
        chk("ovf_pos_sat", sat_flag, 0);
`endif
        drive(1'b1, -8'sd128, 1'b0, -17'sd65536, 1'b0, 8'sd0, 4'd0); step();
`ifdef PE_SATURATE_EN
        chk("ovf_neg_psum", psum_out, -65536);
        chk("ovf_neg_sat", sat_flag, 1);
`else
        chk("ovf_neg_psum", psum_out, 49280);
        chk("ovf_neg_sat", sat_flag, 0);
`endif
        drive(1'b1, 8'sd1, 1'b0, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        chk("sat_sticky", sat_flag, 0
`ifdef PE_SATURATE_EN
            + 1
`endif
        );

        // reset while streaming with a pending shadow weight
        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b1, 8'sd7, 4'd2); step();
        chk("pre_rst_sfull", shadow_full, 1);
        rst = 1'b1;
        drive(1'b1, 8'sd3, 1'b1, 17'sd1, 1'b1, 8'sd5, 4'd2); step();
        chk("mrst_psum", psum_out, 0);
        chk("mrst_act", act_out, 0);
        chk("mrst_avld", act_valid_out, 0);
        chk("mrst_pvld", psum_valid_out, 0);
        chk("mrst_swout", w_swap_out, 0);
        chk("mrst_wout", w_out, 0);
        chk("mrst_wvld", w_valid_out, 0);
        chk("mrst_sfull", shadow_full, 0);
        chk("mrst_sat", sat_flag, 0);
        rst = 1'b0;
        drive(1'b1, 8'sd5, 1'b1, 17'sd123, 1'b0, 8'sd0, 4'd0); step();
        chk("post_rst_psum", psum_out, 123);
        chk("post_rst_pvld", psum_valid_out, 1);
        chk("post_rst_sfull", shadow_full, 0);

        drive(1'b0, 8'sd0, 1'b0, 17'sd0, 1'b0, 8'sd0, 4'd0); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
